// File: rtl/ddram_arbiter_if.sv
// Requester-side and ddram client-port signals
// shared by the DDRAM arbiter and its environment.
interface ddram_arbiter_if;
  logic        vid_req;
  logic [26:0] vid_addr;
  logic [7:0]  vid_burst;
  logic        vid_ack;
  logic        vid_buf;
  logic        aud_req;
  logic [26:0] aud_addr;
  logic        aud_ack;
  logic [63:0] aud_data;
  logic        wr_req;
  logic [26:0] wr_addr;
  logic [63:0] wr_data;
  logic        wr_ack;
  logic [26:0] mem_addr;
  logic [63:0] mem_din;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_rd_ch;
  logic [7:0]  mem_burst;
  logic        mem_dout_ch;
  logic [63:0] mem_dout;
  logic        mem_busy;
  logic        mem_dready;
  logic        err;

  modport slave (
    input  vid_req, vid_addr, vid_burst,
    input  aud_req, aud_addr,
    input  wr_req, wr_addr, wr_data,
    input  mem_dout, mem_busy, mem_dready,
    output vid_ack, vid_buf,
    output aud_ack, aud_data, wr_ack,
    output mem_addr, mem_din,
    output mem_rd, mem_wr, mem_rd_ch,
    output mem_burst, mem_dout_ch, err
  );

  modport master (
    output vid_req, vid_addr, vid_burst,
    output aud_req, aud_addr,
    output wr_req, wr_addr, wr_data,
    output mem_dout, mem_busy, mem_dready,
    input  vid_ack, vid_buf,
    input  aud_ack, aud_data, wr_ack,
    input  mem_addr, mem_din,
    input  mem_rd, mem_wr, mem_rd_ch,
    input  mem_burst, mem_dout_ch, err
  );
endinterface

// File: rtl/ddram_arbiter.sv
// Shares the ddram client port among video line,
// audio word and word-writer requesters.
module ddram_arbiter #(
  parameter int MAX_BURST = 15,
  parameter int TIMEOUT   = 4096
) (
  input  logic           DDRAM_CLK,
  input  logic           reset,
  ddram_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TMAX =
    CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    DRAIN, IDLE, ISSUE,
    WAIT_BUSY, WAIT_DONE, GAP
  } state_t;

  typedef enum logic [1:0] {
    OWN_VID, OWN_AUD, OWN_WR
  } own_t;

  state_t        state;
  own_t          owner;
  logic          rr_wr;
  logic [CW-1:0] cnt;
  logic          vbuf;
  logic [7:0]    vburst;
  logic          go_vid;
  logic          go_aud;
  logic          go_wr;
  logic          done;

  always_comb begin
    vburst = bus.vid_burst;
    if (bus.vid_burst == 8'd0)
      vburst = 8'd1;
    else if (bus.vid_burst > 8'(MAX_BURST))
      vburst = 8'(MAX_BURST);
  end

  // video always wins; audio/writer alternate
  assign go_vid = bus.vid_req;
  assign go_aud = ~go_vid & bus.aud_req &
                  (~rr_wr | ~bus.wr_req);
  assign go_wr  = ~go_vid & ~go_aud &
                  bus.wr_req;

  assign done = (owner == OWN_WR) ?
                ~bus.mem_busy : bus.mem_dready;

  assign bus.vid_buf     = vbuf;
  assign bus.mem_dout_ch = vbuf;

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state         <= DRAIN;
      owner         <= OWN_VID;
      rr_wr         <= 1'b0;
      cnt           <= '0;
      vbuf          <= 1'b0;
      bus.vid_ack   <= 1'b0;
      bus.aud_ack   <= 1'b0;
      bus.wr_ack    <= 1'b0;
      bus.aud_data  <= '0;
      bus.mem_addr  <= '0;
      bus.mem_din   <= '0;
      bus.mem_rd    <= 1'b0;
      bus.mem_wr    <= 1'b0;
      bus.mem_rd_ch <= 1'b0;
      bus.mem_burst <= 8'd1;
      bus.err       <= 1'b0;
    end else begin
      bus.vid_ack <= 1'b0;
      bus.aud_ack <= 1'b0;
      bus.wr_ack  <= 1'b0;
      unique case (state)
        DRAIN: begin
          if (!bus.mem_busy) state <= IDLE;
        end
        IDLE: begin
          if (!bus.mem_busy &&
              (go_vid | go_aud | go_wr)) begin
            state         <= ISSUE;
            bus.mem_burst <= 8'd1;
            unique case (1'b1)
              go_vid: begin
                owner         <= OWN_VID;
                bus.mem_addr  <= bus.vid_addr;
                bus.mem_burst <= vburst;
                bus.mem_rd_ch <= ~vbuf;
                bus.mem_rd    <= 1'b1;
              end
              go_aud: begin
                owner         <= OWN_AUD;
                bus.mem_addr  <= bus.aud_addr;
                bus.mem_rd_ch <= vbuf;
                bus.mem_rd    <= 1'b1;
                rr_wr         <= 1'b1;
              end
              default: begin
                owner        <= OWN_WR;
                bus.mem_addr <= bus.wr_addr;
                bus.mem_din  <= bus.wr_data;
                bus.mem_wr   <= 1'b1;
                rr_wr        <= 1'b0;
              end
            endcase
          end
        end
        ISSUE: begin
          bus.mem_rd <= 1'b0;
          bus.mem_wr <= 1'b0;
          cnt        <= '0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          cnt <= cnt + 1'b1;
          if (bus.mem_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == TMAX) begin
            bus.err <= 1'b1;
            state   <= DRAIN;
          end
        end
        WAIT_DONE: begin
          cnt <= cnt + 1'b1;
          if (done) begin
            bus.vid_ack <= (owner == OWN_VID);
            bus.aud_ack <= (owner == OWN_AUD);
            bus.wr_ack  <= (owner == OWN_WR);
            if (owner == OWN_VID)
              vbuf <= ~vbuf;
            if (owner == OWN_AUD)
              bus.aud_data <= bus.mem_dout;
            state <= GAP;
          end else if (cnt == TMAX) begin
            bus.err <= 1'b1;
            state   <= DRAIN;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= DRAIN;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ddram_arbiter.sv
// Randomized bench for ddram_arbiter: a ddram client model
// plus a transaction-level grant-order and data reference.
module tb_ddram_arbiter;
  localparam int TIMEOUT = 4096;
  localparam int VID = 0;
  localparam int AUD = 1;
  localparam int WRT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ddram_arbiter_if bus();

  ddram_arbiter dut (
    .DDRAM_CLK(clk),
    .reset    (reset),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic        hold_busy = 1'b1;
  logic        m_busy = 1'b0;
  logic        m_dready = 1'b0;
  logic [63:0] m_dout = '0;
  bit          model_en = 1'b1;

  assign bus.mem_busy   = hold_busy | m_busy;
  assign bus.mem_dready = m_dready;
  assign bus.mem_dout   = m_dout;

  typedef struct {
    bit          is_wr;
    logic [26:0] addr;
    logic [63:0] din;
    logic [7:0]  burst;
    logic        ch;
  } issue_t;

  issue_t issues[$];
  bit     exp_vbuf = 1'b0;
  bit     rr_aud = 1'b1;

  function automatic logic [63:0] word_of(input logic [26:0] a);
    return {5'd0, a, 5'd0, ~a} ^ 64'hA5C3_0F1E_9B7D_2468;
  endfunction

  function automatic logic [7:0] exp_burst(input logic [7:0] b);
    if (b == 8'd0) return 8'd1;
    if (b > 8'd15) return 8'd15;
    return b;
  endfunction

  // ddram client model: busy 2 cycles after a strobe edge
  initial begin : ddr_model
    bit          rd_q;
    bit          wr_q;
    bit          is_rd;
    logic [26:0] a;
    int          n;
    rd_q = 1'b0;
    wr_q = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && ((bus.mem_rd === 1'b1 && !rd_q) ||
                       (bus.mem_wr === 1'b1 && !wr_q))) begin
        is_rd = (bus.mem_rd === 1'b1);
        a = bus.mem_addr;
        n = is_rd ? int'(bus.mem_burst) : 0;
        @(negedge clk);
        m_busy = 1'b1;
        repeat (n + int'($urandom_range(2, 5))) @(negedge clk);
        if (is_rd) begin
          m_dout = word_of(a);
          m_dready = 1'b1;
          @(negedge clk);
          m_dready = 1'b0;
        end
        m_busy = 1'b0;
        rd_q = 1'b0;
        wr_q = 1'b0;
      end else begin
        rd_q = (bus.mem_rd === 1'b1);
        wr_q = (bus.mem_wr === 1'b1);
      end
    end
  end

  initial begin : issue_mon
    bit     rq;
    bit     wq;
    issue_t t;
    rq = 1'b0;
    wq = 1'b0;
    forever begin
      @(negedge clk);
      if ((bus.mem_rd === 1'b1 && !rq) ||
          (bus.mem_wr === 1'b1 && !wq)) begin
        t.is_wr = (bus.mem_wr === 1'b1);
        t.addr  = bus.mem_addr;
        t.din   = bus.mem_din;
        t.burst = bus.mem_burst;
        t.ch    = bus.mem_rd_ch;
        issues.push_back(t);
      end
      rq = (bus.mem_rd === 1'b1);
      wq = (bus.mem_wr === 1'b1);
    end
  end

  task automatic wait_ack(input int bound, output int who);
    who = -1;
    for (int i = 0; i < bound && who < 0; i++) begin
      @(negedge clk);
      if (bus.vid_ack === 1'b1) who = VID;
      else if (bus.aud_ack === 1'b1) who = AUD;
      else if (bus.wr_ack === 1'b1) who = WRT;
    end
  endtask

  task automatic wait_strobe(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit strobe;
    reset = 1'b1;
    hold_busy = 1'b1;
    bus.vid_req = 1'b0;
    bus.vid_addr = '0;
    bus.vid_burst = '0;
    bus.aud_req = 1'b0;
    bus.aud_addr = '0;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.vid_ack, bus.aud_ack, bus.wr_ack, bus.mem_rd,
         bus.mem_wr, bus.mem_rd_ch, bus.mem_dout_ch,
         bus.vid_buf, bus.err} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000000000",
               {bus.vid_ack, bus.aud_ack, bus.wr_ack, bus.mem_rd,
                bus.mem_wr, bus.mem_rd_ch, bus.mem_dout_ch,
                bus.vid_buf, bus.err});
    end
    n_cmp++;
    if (bus.mem_burst !== 8'd1) begin
      n_bad++;
      $display("FAIL reset_burst got %0d want 1", bus.mem_burst);
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_din, bus.aud_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_data got %h %h %h want 0",
               bus.mem_addr, bus.mem_din, bus.aud_data);
    end
    bus.vid_addr = 27'h100;
    bus.vid_burst = 8'd15;
    bus.vid_req = 1'b1;
    reset = 1'b0;
    strobe = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) strobe = 1'b1;
    end
    n_cmp++;
    if (strobe) begin
      n_bad++;
      $display("FAIL drain_strobe got strobe while busy want none");
    end
    hold_busy = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_rd !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_exit got mem_rd=%b want 0", bus.mem_rd);
    end
  endtask

  task automatic test_video_line();
    bit seen;
    int who;
    wait_strobe(8, seen);
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL vid_issue got no mem_rd want pulse");
    end
    n_cmp++;
    if ({bus.mem_addr, bus.mem_burst, bus.mem_rd_ch} !==
        {27'h100, 8'd15, 1'b1}) begin
      n_bad++;
      $display("FAIL vid_cmd got %h/%0d/%b want 100/15/1",
               bus.mem_addr, bus.mem_burst, bus.mem_rd_ch);
    end
    wait_ack(200, who);
    n_cmp++;
    if (who !== VID) begin
      n_bad++;
      $display("FAIL vid_ack got owner %0d want %0d", who, VID);
    end
    bus.vid_req = 1'b0;
    exp_vbuf = ~exp_vbuf;
    n_cmp++;
    if ({bus.vid_buf, bus.mem_dout_ch} !== {exp_vbuf, exp_vbuf}) begin
      n_bad++;
      $display("FAIL vid_buf got %b%b want %b%b", bus.vid_buf,
               bus.mem_dout_ch, exp_vbuf, exp_vbuf);
    end
  endtask

  task automatic test_round_robin();
    int     who;
    int     expw;
    issue_t t;
    issues.delete();
    bus.aud_addr = 27'($urandom);
    bus.wr_addr = 27'($urandom);
    bus.wr_data = {$urandom, $urandom};
    bus.aud_req = 1'b1;
    bus.wr_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      expw = rr_aud ? AUD : WRT;
      wait_ack(300, who);
      n_cmp++;
      if (who !== expw) begin
        n_bad++;
        $display("FAIL rr_order[%0d] got %0d want %0d", k, who, expw);
      end
      n_cmp++;
      if (issues.size() == 0) begin
        n_bad++;
        $display("FAIL rr_issue[%0d] got no issue want one", k);
      end else begin
        t = issues.pop_front();
        if (expw == AUD) begin
          n_cmp++;
          if ({t.is_wr, t.addr, t.burst, t.ch} !==
              {1'b0, bus.aud_addr, 8'd1, exp_vbuf}) begin
            n_bad++;
            $display("FAIL rr_aud_cmd[%0d] got %b %h %0d %b want 0 %h 1 %b",
                     k, t.is_wr, t.addr, t.burst, t.ch,
                     bus.aud_addr, exp_vbuf);
          end
          if (bus.aud_data !== word_of(bus.aud_addr)) begin
            n_bad++;
            $display("FAIL rr_aud_data[%0d] got %h want %h", k,
                     bus.aud_data, word_of(bus.aud_addr));
          end
          bus.aud_addr = 27'($urandom);
        end else begin
          n_cmp++;
          if ({t.is_wr, t.addr, t.din} !==
              {1'b1, bus.wr_addr, bus.wr_data}) begin
            n_bad++;
            $display("FAIL rr_wr_cmd[%0d] got %b %h %h want 1 %h %h",
                     k, t.is_wr, t.addr, t.din, bus.wr_addr, bus.wr_data);
          end
          bus.wr_addr = 27'($urandom);
          bus.wr_data = {$urandom, $urandom};
        end
      end
      rr_aud = ~rr_aud;
    end
    bus.aud_req = 1'b0;
    bus.wr_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_video_priority();
    int     who;
    bit     busy_seen;
    issue_t t;
    int     order[3];
    issues.delete();
    order = '{WRT, VID, AUD};
    bus.wr_addr = 27'($urandom);
    bus.wr_data = {$urandom, $urandom};
    bus.wr_req = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 20 && !busy_seen; i++) begin
      @(negedge clk);
      if (bus.mem_busy === 1'b1 && issues.size() > 0) busy_seen = 1'b1;
    end
    n_cmp++;
    if (!busy_seen) begin
      n_bad++;
      $display("FAIL prio_wr_busy got no busy want busy");
    end
    bus.vid_addr = 27'($urandom);
    bus.vid_burst = 8'($urandom_range(1, 15));
    bus.vid_req = 1'b1;
    bus.aud_addr = 27'($urandom);
    bus.aud_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(300, who);
      n_cmp++;
      if (who !== order[k]) begin
        n_bad++;
        $display("FAIL prio_order[%0d] got %0d want %0d", k, who, order[k]);
      end
      if (issues.size() > 0) t = issues.pop_front();
      n_cmp++;
      case (order[k])
        WRT: begin
          bus.wr_req = 1'b0;
          rr_aud = 1'b1;
          if ({t.is_wr, t.addr, t.din} !==
              {1'b1, bus.wr_addr, bus.wr_data}) begin
            n_bad++;
            $display("FAIL prio_wr_cmd got %h %h want %h %h",
                     t.addr, t.din, bus.wr_addr, bus.wr_data);
          end
        end
        VID: begin
          bus.vid_req = 1'b0;
          if ({t.is_wr, t.addr, t.ch, t.burst} !==
              {1'b0, bus.vid_addr, ~exp_vbuf, bus.vid_burst}) begin
            n_bad++;
            $display("FAIL prio_vid_cmd got %h %b %0d want %h %b %0d",
                     t.addr, t.ch, t.burst, bus.vid_addr, ~exp_vbuf,
                     bus.vid_burst);
          end
          exp_vbuf = ~exp_vbuf;
        end
        default: begin
          bus.aud_req = 1'b0;
          rr_aud = 1'b0;
          if (bus.aud_data !== word_of(bus.aud_addr) || t.ch !== exp_vbuf) begin
            n_bad++;
            $display("FAIL prio_aud got %h ch %b want %h ch %b",
                     bus.aud_data, t.ch, word_of(bus.aud_addr), exp_vbuf);
          end
        end
      endcase
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_burst_clamp();
    logic [7:0] bl[7];
    logic [7:0] eb;
    bit         seen;
    int         who;
    bl = '{8'd0, 8'd40, 8'd15, 8'd16, 8'd1,
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    for (int k = 0; k < 7; k++) begin
      eb = exp_burst(bl[k]);
      bus.vid_addr = 27'($urandom);
      bus.vid_burst = bl[k];
      bus.vid_req = 1'b1;
      wait_strobe(10, seen);
      n_cmp++;
      if (!seen || {bus.mem_burst, bus.mem_rd_ch, bus.mem_addr} !==
                   {eb, ~exp_vbuf, bus.vid_addr}) begin
        n_bad++;
        $display("FAIL burst[%0d] in %0d got %0d ch %b want %0d ch %b",
                 k, bl[k], bus.mem_burst, bus.mem_rd_ch, eb, ~exp_vbuf);
      end
      wait_ack(300, who);
      bus.vid_req = 1'b0;
      exp_vbuf = ~exp_vbuf;
      n_cmp++;
      if (who !== VID || bus.vid_buf !== exp_vbuf) begin
        n_bad++;
        $display("FAIL burst_ack[%0d] got owner %0d buf %b want %0d buf %b",
                 k, who, bus.vid_buf, VID, exp_vbuf);
      end
    end
  endtask

  task automatic test_timeout();
    bit seen;
    bit acked;
    bit early;
    bit err_seen;
    int who;
    model_en = 1'b0;
    bus.aud_addr = 27'($urandom);
    bus.aud_req = 1'b1;
    wait_strobe(10, seen);
    bus.aud_req = 1'b0;
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL to_issue got no strobe want mem_rd");
    end
    acked = 1'b0;
    early = 1'b0;
    for (int i = 0; i < TIMEOUT - 8; i++) begin
      @(negedge clk);
      if (bus.aud_ack === 1'b1 || bus.vid_ack === 1'b1 ||
          bus.wr_ack === 1'b1) acked = 1'b1;
      if (bus.err !== 1'b0) early = 1'b1;
    end
    n_cmp++;
    if (early) begin
      n_bad++;
      $display("FAIL to_early got err before %0d cycles want 0", TIMEOUT - 8);
    end
    err_seen = 1'b0;
    for (int i = 0; i < 16 && !err_seen; i++) begin
      @(negedge clk);
      if (bus.aud_ack === 1'b1) acked = 1'b1;
      if (bus.err === 1'b1) err_seen = 1'b1;
    end
    n_cmp++;
    if (!err_seen) begin
      n_bad++;
      $display("FAIL to_err got err=%b want 1", bus.err);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (acked || bus.vid_buf !== exp_vbuf) begin
      n_bad++;
      $display("FAIL to_noack got ack %b buf %b want ack 0 buf %b",
               acked, bus.vid_buf, exp_vbuf);
    end
    model_en = 1'b1;
    bus.vid_addr = 27'($urandom);
    bus.vid_burst = 8'd4;
    bus.vid_req = 1'b1;
    wait_ack(300, who);
    bus.vid_req = 1'b0;
    exp_vbuf = ~exp_vbuf;
    n_cmp++;
    if (who !== VID || bus.vid_buf !== exp_vbuf || bus.err !== 1'b1) begin
      n_bad++;
      $display("FAIL to_recover got owner %0d buf %b err %b want %0d %b 1",
               who, bus.vid_buf, bus.err, VID, exp_vbuf);
    end
  endtask

  initial begin
    test_reset();
    test_video_line();
    test_round_robin();
    test_video_priority();
    test_burst_clamp();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
